// File: rtl/turfio_cin_align.sv
// TURFIO command-input bit aligner.
// Hunts a 32-bit training word across 32 bit offsets of an ISERDES nibble stream.
module turfio_cin_align #(
    parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
    parameter int unsigned LOCK_COUNT = 16
) (
    input  logic        rxclk_i,
    input  logic        rst_i,
    input  logic [3:0]  data_i,
    input  logic        train_en_i,
    input  logic        realign_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic        locked_o,
    output logic [4:0]  offset_o,
    output logic        fail_o
);

    localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] hist_q;
    logic [2:0]  cnt_q;
    logic [4:0]  offset_q;
    logic [4:0]  offset_d;
    logic [7:0]  match_q;
    logic [7:0]  match_d;
    logic [5:0]  miss_q;
    logic [5:0]  miss_d;
    logic        fail_q;
    logic        fail_d;
    logic        locked_q;
    logic [31:0] word_q;
    logic        valid_q;

    logic [31:0] cand;
    logic        bnd;
    logic        hit;
    logic [7:0]  match_inc;
    logic [5:0]  miss_inc;

    assign cand      = hist_q[offset_q +: 32];
    assign bnd       = (cnt_q == 3'd0);
    assign hit       = (cand == TRAIN_PATTERN);
    assign match_inc = match_q + 8'd1;
    assign miss_inc  = (miss_q == 6'd32) ? miss_q : miss_q + 6'd1;

    // Bit history (earliest bit of each nibble lands highest) and nibble phase.
    always_ff @(posedge rxclk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= {hist_q[59:0], data_i[0], data_i[1], data_i[2], data_i[3]};
            cnt_q  <= cnt_q + 3'd1;
        end
    end

    // Next-state logic for the alignment search and its counters.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        match_d  = match_q;
        miss_d   = miss_q;
        fail_d   = fail_q;
        if (realign_i) begin
            state_d  = IDLE;
            offset_d = '0;
            match_d  = '0;
            miss_d   = '0;
            fail_d   = 1'b0;
        end else if (!train_en_i) begin
            miss_d = '0;
            fail_d = 1'b0;
            if (state_q != LOCKED) begin
                state_d = IDLE;
                match_d = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = HUNT;
                    match_d = '0;
                end
                HUNT, CHECK: begin
                    if (bnd) begin
                        if (hit) begin
                            miss_d  = '0;
                            match_d = (state_q == HUNT) ? 8'd1 : match_inc;
                            state_d = (match_d == LOCK_N) ? LOCKED : CHECK;
                        end else begin
                            state_d  = HUNT;
                            match_d  = '0;
                            offset_d = offset_q + 5'd1;
                            miss_d   = miss_inc;
                            if (miss_inc == 6'd32) begin
                                fail_d = 1'b1;
                            end
                        end
                    end
                end
                LOCKED: state_d = LOCKED;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and counter registers.
    always_ff @(posedge rxclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            offset_q <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            fail_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            fail_q   <= fail_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    // Emit the aligned word once per boundary while locked.
    always_ff @(posedge rxclk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (realign_i) begin
            valid_q <= 1'b0;
        end else if (state_q == LOCKED && bnd) begin
            word_q  <= cand;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign locked_o     = locked_q;
    assign offset_o     = offset_q;
    assign fail_o       = fail_q;

endmodule

// File: tb/tb_turfio_cin_align.sv
// Bench for turfio_cin_align.
// Bit stream is built from words; a monitor scores each aligned word strobe.
module tb_turfio_cin_align;

    localparam logic [31:0] PAT = 32'hA55A6996;

    logic        rxclk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  data_i = '0;
    logic        train_en_i = 1'b0;
    logic        realign_i = 1'b0;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        locked_o;
    logic [4:0]  offset_o;
    logic        fail_o;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int shift = 0;
    int data_start = -1;
    int bad_m = -1;
    bit idle_mode = 1'b0;
    int last_v = 0;
    int nxt;
    int er;
    logic [31:0] mon_e;
    logic [31:0] dtab [4] = '{32'h12345678, 32'hDEADBEEF,
                              32'h00000000, 32'hFFFFFFFF};
    logic [31:0] exp_q [$];

    turfio_cin_align dut (
        .rxclk_i      (rxclk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .train_en_i   (train_en_i),
        .realign_i    (realign_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .locked_o     (locked_o),
        .offset_o     (offset_o),
        .fail_o       (fail_o)
    );

    always #5 rxclk_i = ~rxclk_i;

    always @(posedge rxclk_i or posedge rst_i) begin
        if (rst_i) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    function automatic logic [31:0] word_at(input int m);
        logic [31:0] w;
        if (idle_mode) return 32'hFFFFFFFF;
        if (data_start >= 0 && m >= data_start && m < data_start + 4)
            return dtab[m - data_start];
        w = PAT;
        if (m == bad_m) w = w ^ 32'h1;
        return w;
    endfunction

    function automatic logic stream_bit(input int n);
        int np;
        logic [31:0] w;
        np = n + shift;
        w = word_at(np / 32);
        return w[31 - (np % 32)];
    endfunction

    always @(negedge rxclk_i) begin
        for (int i = 0; i < 4; i++) data_i[i] = stream_bit(4 * edge_n + i);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp_v);
        end
    endtask

    always @(posedge rxclk_i) begin
        #1;
        if (!locked_o) last_v = 0;
        if (word_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got=%h want=none", word_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word_o", word_o, mon_e);
            end
            if (last_v != 0) chk("strobe_gap", edge_n - last_v, 8);
            last_v = edge_n;
        end
    end

    task automatic to_edge(input int e);
        while (edge_n < e) begin
            @(posedge rxclk_i);
            #1;
        end
    endtask

    task automatic wait_lock(input string nm, input int e_exp);
        int i;
        i = 0;
        while (!locked_o && i < 1200) begin
            @(posedge rxclk_i);
            #1;
            i++;
        end
        if (locked_o) begin
            chk(nm, edge_n, e_exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s timeout got=%0d want=%0d", nm, edge_n, e_exp);
        end
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 200) begin
            @(posedge rxclk_i);
            #1;
            i++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(word_at(first + i));
    endtask

    task automatic do_reset(input int sh, input bit idle);
        @(negedge rxclk_i);
        rst_i = 1'b1;
        train_en_i = 1'b0;
        realign_i = 1'b0;
        shift = sh;
        idle_mode = idle;
        data_start = -1;
        bad_m = -1;
        @(negedge rxclk_i);
        @(negedge rxclk_i);
        train_en_i = 1'b1;
        rst_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge rxclk_i);
        chk("rst_word", word_o, 0);
        chk("rst_valid", word_valid_o, 0);
        chk("rst_locked", locked_o, 0);
        chk("rst_offset", offset_o, 0);
        chk("rst_fail", fail_o, 0);

        // lock at offset 0
        do_reset(0, 1'b0);
        wait_lock("lock_edge_off0", 129);
        chk("offset_off0", offset_o, 0);
        chk("fail_off0", fail_o, 0);
        push_words((edge_n - 1) / 8, 2);
        drain("drain_off0");

        // lock at offset 5, then payload words
        do_reset(5, 1'b0);
        wait_lock("lock_edge_off5", 169);
        chk("offset_off5", offset_o, 5);
        chk("fail_off5", fail_o, 0);
        nxt = (edge_n - 1) / 8;
        data_start = nxt + 2;
        push_words(nxt, 7);
        drain("drain_off5");

        // realign during a boundary cycle while locked
        @(negedge rxclk_i);
        while (edge_n % 8 != 0) @(negedge rxclk_i);
        realign_i = 1'b1;
        er = edge_n + 1;
        @(posedge rxclk_i);
        #1;
        chk("realign_locked", locked_o, 0);
        chk("realign_offset", offset_o, 0);
        chk("realign_valid", word_valid_o, 0);
        @(negedge rxclk_i);
        realign_i = 1'b0;
        wait_lock("relock_edge", er + 168);
        chk("relock_offset", offset_o, 5);

        // asynchronous reset while locked
        @(posedge rxclk_i);
        #3;
        rst_i = 1'b1;
        data_start = -1;
        #1;
        chk("arst_word", word_o, 0);
        chk("arst_valid", word_valid_o, 0);
        chk("arst_locked", locked_o, 0);
        chk("arst_offset", offset_o, 0);
        chk("arst_fail", fail_o, 0);
        @(negedge rxclk_i);
        @(negedge rxclk_i);
        rst_i = 1'b0;
        wait_lock("relock_after_rst", 169);

        // corrupt one word at match count 10
        do_reset(5, 1'b0);
        bad_m = 15;
        to_edge(121);
        chk("c_offset_pre", offset_o, 5);
        chk("c_locked_pre", locked_o, 0);
        to_edge(129);
        chk("c_offset_step", offset_o, 6);
        to_edge(329);
        chk("c_offset_31", offset_o, 31);
        to_edge(337);
        chk("c_offset_wrap", offset_o, 0);
        to_edge(369);
        chk("c_fail_31miss", fail_o, 0);
        to_edge(377);
        chk("c_fail_32miss", fail_o, 1);
        chk("c_offset_back", offset_o, 5);
        wait_lock("c_relock_edge", 505);
        chk("c_relock_offset", offset_o, 5);
        chk("c_fail_sticky", fail_o, 1);
        push_words((edge_n - 1) / 8, 2);
        @(negedge rxclk_i);
        train_en_i = 1'b0;
        @(posedge rxclk_i);
        #1;
        chk("c_lock_persists", locked_o, 1);
        chk("c_fail_cleared", fail_o, 0);
        drain("drain_corrupt");

        // idle stream, no pattern
        do_reset(0, 1'b1);
        to_edge(249);
        chk("d_fail_31miss", fail_o, 0);
        to_edge(257);
        chk("d_fail_32miss", fail_o, 1);
        chk("d_locked", locked_o, 0);
        to_edge(321);
        chk("d_fail_40", fail_o, 1);
        chk("d_locked_40", locked_o, 0);
        chk("d_offset_40", offset_o, 8);
        @(negedge rxclk_i);
        train_en_i = 1'b0;
        @(posedge rxclk_i);
        #1;
        chk("d_fail_drop", fail_o, 0);
        chk("d_offset_kept", offset_o, 8);
        chk("d_locked_drop", locked_o, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/turfio_cin_align.md
TURFIO_CIN_ALIGN -- requirements
Module: turfio_cin_align

Interface
REQ-001 SHALL have parameter TRAIN_PATTERN, default 32'hA55A6996, the training word the link transmits while training.
REQ-002 SHALL have parameter LOCK_COUNT, default 16, the number of consecutive matching words required to lock (range 1..255).
REQ-003 SHALL have port rxclk_i, input, 1 bit: the single clock; all logic is in the rxclk domain.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port data_i, input, 4 bits: ISERDES nibble, one per rxclk_i cycle; data_i[0] is the earliest bit.
REQ-006 SHALL have port train_en_i, input, 1 bit: level; high enables the alignment search.
REQ-007 SHALL have port realign_i, input, 1 bit: pulse; drops lock and restarts from offset 0.
REQ-008 SHALL have port word_o, output, 32 bits: aligned word; the first-received bit is the MSB.
REQ-009 SHALL have port word_valid_o, output, 1 bit: one-cycle strobe qualifying word_o.
REQ-010 SHALL have port locked_o, output, 1 bit: high while the FSM is in LOCKED.
REQ-011 SHALL have port offset_o, output, 5 bits: current bit-alignment offset.
REQ-012 SHALL have port fail_o, output, 1 bit: sticky flag set when all 32 offsets were tried without a lock.

Function
REQ-013 SHALL shift a 64-bit history every cycle: hist <= {hist[59:0], data_i[0], data_i[1], data_i[2], data_i[3]}, so the newest bit lands at the LSB.
REQ-014 SHALL run a free-running 3-bit nibble counter cnt, incrementing every cycle and wrapping 7->0; a boundary cycle is a cycle with cnt==0.
REQ-015 SHALL form the candidate word as hist[offset+31 : offset], evaluated on the registered hist in the boundary cycle.
REQ-016 SHALL implement FSM states IDLE, HUNT, CHECK and LOCKED, with reset state IDLE.
REQ-017 IDLE: SHALL move to HUNT on the next edge when train_en_i=1, with match count 0 and offset unchanged.
REQ-018 HUNT, boundary cycle, candidate==TRAIN_PATTERN: SHALL move to CHECK with match count=1.
REQ-019 HUNT, boundary cycle, mismatch: SHALL set offset <= offset+1, wrapping 31->0, and remain in HUNT.
REQ-020 CHECK, boundary cycle, match: SHALL increment the match count and move to LOCKED when the count reaches LOCK_COUNT.
REQ-021 CHECK, boundary cycle, mismatch: SHALL clear the match count, increment offset (with wrap) and return to HUNT.
REQ-022 CHECK with LOCK_COUNT=1: SHALL lock from HUNT on the first match, going directly to LOCKED.
REQ-023 Consecutive mismatches: SHALL count them in a 6-bit counter, cleared on any match; reaching 32 sets fail_o.
REQ-024 fail_o: SHALL stay set, without stopping the hunt, until train_en_i=0 or realign_i=1.
REQ-025 train_en_i=0 in HUNT or CHECK: SHALL return to IDLE with match count cleared and offset kept.
REQ-026 train_en_i=0 in LOCKED: SHALL leave the FSM in LOCKED; lock persists into normal operation.
REQ-027 LOCKED: SHALL freeze offset and, on the edge ending each boundary cycle, register word_o<=candidate and word_valid_o<=1.
REQ-028 word_valid_o: SHALL be 0 in all other cycles, giving exactly one strobe per 8 cycles and a latency of 1 cycle from the boundary.
REQ-029 Outside LOCKED: SHALL hold word_o at its last value and keep word_valid_o=0.
REQ-030 realign_i=1, in any state: SHALL force IDLE, offset=0, match count=0, mismatch count=0, fail_o=0 and locked_o=0 on the next edge.
REQ-031 realign_i and train_en_i high in the same cycle: realign_i SHALL win; HUNT is entered on the following edge if train_en_i is still high.
REQ-032 offset_o and locked_o: SHALL be registered state, not combinational decodes of inputs.

Reset
REQ-033 rst_i=1: SHALL immediately force state=IDLE, hist=0, cnt=0, offset=0, match count=0, mismatch count=0, word_o=0, word_valid_o=0, locked_o=0 and fail_o=0, including mid-lock or mid-word.
REQ-034 After rst_i deasserts: SHALL restart cnt from 0 on the first rising edge.

Verification
REQ-035 Lock at offset 0: repeat TRAIN_PATTERN with its MSB at hist[31] in boundary cycles, train_en_i=1 -> locked_o rises after 16 consecutive boundary matches, offset_o=0, fail_o=0.
REQ-036 Lock at offset 5: advance the same stream by 5 bits -> lock with offset_o=5; then word_valid_o pulses every 8 cycles with word_o=32'hA55A6996.
REQ-037 Corrupted word in CHECK: corrupt one word at match count 10 -> HUNT, offset steps 1..31 and wraps, fail_o=1 after 32 mismatches, relock at the original offset, fail_o stays 1.
REQ-038 No pattern: 0xF idle stream for 40 boundaries -> fail_o=1 at the 32nd boundary, locked_o=0; drop train_en_i -> fail_o=0 and state IDLE.
REQ-039 Realign: pulse realign_i while LOCKED -> next cycle locked_o=0, offset_o=0, word_valid_o=0; with realign_i and train_en_i both high, HUNT is entered one cycle later.
REQ-040 Async reset: assert rst_i between clock edges while LOCKED -> all outputs 0 before the next rxclk_i edge; after release, relock requires a fresh LOCK_COUNT matches.
